// File: rtl/accel_req_queue_pkg.sv
// Shared accelerator types: request entry, id width, helpers.
// Used by accel_req_queue and accel_req_fifo_mem.
package accel_req_queue_pkg;

  localparam int TRANS_ID_BITS = 3;
  localparam int ACC_XLEN      = 64;

  typedef struct packed {
    logic [31:0]              instr;
    logic [ACC_XLEN-1:0]      rs1;
    logic [ACC_XLEN-1:0]      rs2;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } accel_req_entry_t;

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/accel_req_fifo_mem.sv
// Register-file storage for the accelerator request queue.
// One write port, one asynchronous read port.
module accel_req_fifo_mem
  import accel_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  accel_req_entry_t wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output accel_req_entry_t rdata_o
);

  accel_req_entry_t r_mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/accel_req_queue.sv
// Speculative request queue in front of a vector accelerator.
// Optional stats counters: define ACCEL_REQ_QUEUE_STATS_EN.
module accel_req_queue
  import accel_req_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int XLEN            = 64,
  parameter int MAX_OUTSTANDING = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [XLEN-1:0]          issue_rs1_i,
  input  logic [XLEN-1:0]          issue_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic                     commit_i,
  input  logic                     flush_i,
  output logic                     acc_req_valid_o,
  input  logic                     acc_req_ready_i,
  output logic [31:0]              acc_req_instr_o,
  output logic [XLEN-1:0]          acc_req_rs1_o,
  output logic [XLEN-1:0]          acc_req_rs2_o,
  output logic [TRANS_ID_BITS-1:0] acc_req_trans_id_o,
  input  logic                     acc_resp_valid_i,
  input  logic [XLEN-1:0]          acc_resp_result_i,
  input  logic [TRANS_ID_BITS-1:0] acc_resp_trans_id_i,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     busy_o
`ifdef ACCEL_REQ_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_full_cycles_o,
  output logic [31:0]              stat_backpressure_cycles_o,
  output logic [31:0]              stat_flushed_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_cm_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [OW-1:0]   r_outstanding;
  logic            r_wb_valid;
  logic [XLEN-1:0] r_wb_result;
  logic [TRANS_ID_BITS-1:0] r_wb_id;

  logic             w_full;
  logic             w_push;
  logic             w_commit;
  logic             w_send;
  logic [PW-1:0]    w_cm_next;
  accel_req_entry_t w_wdata;
  accel_req_entry_t w_head;

  // Full depends only on registered pointers: no ready path from a pop.
  assign w_full    = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
  assign w_push    = issue_valid_i & ~w_full & ~flush_i;
  assign w_commit  = commit_i & ((r_cm_ptr != r_wr_ptr) | w_push);
  assign w_cm_next = r_cm_ptr + PW'(w_commit);
  assign w_send    = acc_req_valid_o & acc_req_ready_i;

  assign issue_ready_o   = ~w_full;
  assign acc_req_valid_o = (r_rd_ptr != r_cm_ptr)
                         & (r_outstanding < OW'(MAX_OUTSTANDING));
  assign busy_o = (r_rd_ptr != r_wr_ptr) | (r_outstanding != '0);

  always_comb begin
    w_wdata          = '0;
    w_wdata.instr    = issue_instr_i;
    w_wdata.rs1      = ACC_XLEN'(issue_rs1_i);
    w_wdata.rs2      = ACC_XLEN'(issue_rs2_i);
    w_wdata.trans_id = issue_trans_id_i;
  end

  accel_req_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr[AW-1:0]),
    .wdata_i (w_wdata),
    .raddr_i (r_rd_ptr[AW-1:0]),
    .rdata_o (w_head)
  );

  assign acc_req_instr_o    = acc_req_valid_o ? w_head.instr : '0;
  assign acc_req_rs1_o      = acc_req_valid_o ? w_head.rs1[XLEN-1:0] : '0;
  assign acc_req_rs2_o      = acc_req_valid_o ? w_head.rs2[XLEN-1:0] : '0;
  assign acc_req_trans_id_o = acc_req_valid_o ? w_head.trans_id : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_cm_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_send);
      r_cm_ptr <= w_cm_next;
      r_wr_ptr <= flush_i ? w_cm_next : r_wr_ptr + PW'(w_push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (w_send & ~acc_resp_valid_i) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (~w_send & acc_resp_valid_i & (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid  <= 1'b0;
      r_wb_result <= '0;
      r_wb_id     <= '0;
    end else begin
      r_wb_valid <= acc_resp_valid_i;
      if (acc_resp_valid_i) begin
        r_wb_result <= acc_resp_result_i;
        r_wb_id     <= acc_resp_trans_id_i;
      end
    end
  end

  assign wb_valid_o    = r_wb_valid;
  assign wb_result_o   = r_wb_result;
  assign wb_trans_id_o = r_wb_id;

  a_resp_has_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    acc_resp_valid_i |-> (r_outstanding != '0)
  );

`ifdef ACCEL_REQ_QUEUE_STATS_EN
  logic [31:0] r_stat_full;
  logic [31:0] r_stat_bp;
  logic [31:0] r_stat_flushed;
  logic [PW-1:0] w_dropped;

  assign w_dropped = flush_i ? (r_wr_ptr - w_cm_next) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_full    <= '0;
      r_stat_bp      <= '0;
      r_stat_flushed <= '0;
    end else begin
      r_stat_full    <= sat_add32(r_stat_full, 32'(w_full));
      r_stat_bp      <= sat_add32(r_stat_bp,
                          32'(acc_req_valid_o & ~acc_req_ready_i));
      r_stat_flushed <= sat_add32(r_stat_flushed, 32'(w_dropped));
    end
  end

  assign stat_full_cycles_o         = r_stat_full;
  assign stat_backpressure_cycles_o = r_stat_bp;
  assign stat_flushed_o             = r_stat_flushed;
`endif

endmodule
